// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the instruction stream encoder.
//   - Primary opcode constants (the same values the main decoder matches).
//   - op_sel enumeration used on the field bus.
//   - FSM state type for the loader.
//   - itypeWord(): helper that packs an I-type instruction.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Codes 6 and 7 are deliberately left out: they are the illegal selections.
  typedef enum logic [2:0] {
    SEL_RTYPE = 3'd0,
    SEL_J     = 3'd1,
    SEL_BEQ   = 3'd2,
    SEL_ADDI  = 3'd3,
    SEL_LW    = 3'd4,
    SEL_SW    = 3'd5
  } opSel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } encState_e;

  function automatic logic [31:0] itypeWord(input logic [5:0]  opcode,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm16);
    return {opcode, rs, rt, imm16};
  endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: decoded-field bus with valid/ready handshake.
//   in_valid  master->slave  field set valid
//   in_ready  slave->master  encoder can accept
//   op_sel    3   operation class (0 RTYPE,1 J,2 BEQ,3 ADDI,4 LW,5 SW,6-7 illegal)
//   rs/rt/rd/shamt 5 each, funct 6, imm16 16, target 26
// Modports: master (field source), slave (encoder).
interface instr_stream_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target;

  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, funct, imm16, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm16, target,
    output in_ready
  );
endinterface

// File: rtl/instr_field_encoder.sv
// instr_field_encoder: combinational MIPS instruction assembler.
// Inputs : op_sel, rs, rt, rd, shamt, funct, imm16, target
// Outputs: word    - 32-bit encoded instruction (0 when illegal)
//          illegal - op_sel is not one of the six supported classes
// Fields not used by the selected class are ignored.
module instr_field_encoder
  import mips_pkg::*;
(
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_sel)
      SEL_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      SEL_J:     word = {OP_J, target};
      SEL_BEQ:   word = itypeWord(OP_BEQ,  rs, rt, imm16);
      SEL_ADDI:  word = itypeWord(OP_ADDI, rs, rt, imm16);
      SEL_LW:    word = itypeWord(OP_LW,   rs, rt, imm16);
      SEL_SW:    word = itypeWord(OP_SW,   rs, rt, imm16);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: sequential MIPS instruction encoder and
// instruction-memory loader. Accepts field sets over fieldBus, encodes them
// and writes the words to consecutive instruction-memory addresses.
// Ports:
//   clk, rst_n (async active-low), load_start, load_end (single-cycle pulses)
//   fieldBus   slave side of the decoded-field valid/ready bus
//   imem_we / imem_addr / imem_wdata  registered one-cycle write
//   word_count words written this load, full (DEPTH words written)
//   busy (LOAD), done (DONE), err (sticky illegal op_sel this load)
//   checksum   running XOR of written words (only with ENC_CHECKSUM_EN)
// Optional feature macro: ENC_CHECKSUM_EN.
module instr_stream_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_end,
  instr_stream_encoder_if.slave fieldBus,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic [ADDR_W:0]      word_count,
  output logic                 full,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  encState_e          state;
  logic [31:0]        encWord;
  logic               encIllegal;
  logic               accept;
  logic               startLoad;
  logic [ADDR_W:0]    countNext;

  instr_field_encoder u_fieldEnc (
    .op_sel  (fieldBus.op_sel),
    .rs      (fieldBus.rs),
    .rt      (fieldBus.rt),
    .rd      (fieldBus.rd),
    .shamt   (fieldBus.shamt),
    .funct   (fieldBus.funct),
    .imm16   (fieldBus.imm16),
    .target  (fieldBus.target),
    .word    (encWord),
    .illegal (encIllegal)
  );

  assign fieldBus.in_ready = busy && !full;
  assign accept            = fieldBus.in_valid && fieldBus.in_ready;
  // load_start is ignored in LOAD, so a restart and a transfer never coincide.
  assign startLoad         = load_start && (state != ST_LOAD);
  assign countNext         = word_count + 1'b1;

  // Loader FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_LOAD: begin
          // load_end wins over a simultaneous load_start.
          if (load_end) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write port, counters and sticky error. The low bits of word_count are
  // the write address, so no separate address counter is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (startLoad) begin
        word_count <= '0;
        full       <= 1'b0;
        err        <= 1'b0;
`ifdef ENC_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else if (accept) begin
        if (encIllegal) begin
          err <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= encWord;
          word_count <= countNext;
          full       <= (countNext == DEPTH);
`ifdef ENC_CHECKSUM_EN
          checksum   <= checksum ^ encWord;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: directed bench for instr_stream_encoder.
// Instance A uses ADDR_W=6, instance B uses ADDR_W=2 for the full/stall case.
// Checksum checks are included when ENC_CHECKSUM_EN is defined.
module tb_instr_stream_encoder;

  logic clk;
  logic rst_n;
  logic startA, endA, startB, endB;

  logic        weA, fullA, busyA, doneA, errA;
  logic [5:0]  addrA;
  logic [31:0] wdataA;
  logic [6:0]  wcA;
  logic        weB, fullB, busyB, doneB, errB;
  logic [1:0]  addrB;
  logic [31:0] wdataB;
  logic [2:0]  wcB;
`ifdef ENC_CHECKSUM_EN
  logic [31:0] csumA, csumB;
`endif

  int nVec = 0;
  int nErr = 0;

  instr_stream_encoder_if ifA ();
  instr_stream_encoder_if ifB ();

  instr_stream_encoder #(.ADDR_W(6)) dutA (
    .clk(clk), .rst_n(rst_n), .load_start(startA), .load_end(endA),
    .fieldBus(ifA.slave),
    .imem_we(weA), .imem_addr(addrA), .imem_wdata(wdataA),
    .word_count(wcA), .full(fullA), .busy(busyA), .done(doneA), .err(errA)
`ifdef ENC_CHECKSUM_EN
    , .checksum(csumA)
`endif
  );

  instr_stream_encoder #(.ADDR_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .load_start(startB), .load_end(endB),
    .fieldBus(ifB.slave),
    .imem_we(weB), .imem_addr(addrB), .imem_wdata(wdataB),
    .word_count(wcB), .full(fullB), .busy(busyB), .done(doneB), .err(errB)
`ifdef ENC_CHECKSUM_EN
    , .checksum(csumB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setA(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt);
    ifA.op_sel = op; ifA.rs = rs; ifA.rt = rt; ifA.rd = rd;
    ifA.shamt = sh; ifA.funct = fn; ifA.imm16 = imm; ifA.target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    startA = 0; endA = 0; startB = 0; endB = 0;
    ifA.in_valid = 0; setA(3'd0, 0, 0, 0, 0, 0, 0, 0);
    ifB.in_valid = 0; ifB.op_sel = 3'd3; ifB.rs = 5'd1; ifB.rt = 5'd2; ifB.rd = 0;
    ifB.shamt = 0; ifB.funct = 0; ifB.imm16 = 0; ifB.target = 0;

    // Reset values
    #23;
    chk("rst_we", weA, 0);
    chk("rst_ready", ifA.in_ready, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_done", doneA, 0);
    chk("rst_full", fullA, 0);
    chk("rst_err", errA, 0);
    chk("rst_addr", addrA, 0);
    chk("rst_wdata", wdataA, 0);
    chk("rst_wc", wcA, 0);
`ifdef ENC_CHECKSUM_EN
    chk("rst_csum", csumA, 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busyA, 0);

    // First load: single RTYPE, unused fields non-zero
    startA = 1; tick(); startA = 0;
    chk("ld_busy", busyA, 1);
    chk("ld_ready", ifA.in_ready, 1);
    chk("ld_wc0", wcA, 0);
    setA(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'h3FFFFFF);
    ifA.in_valid = 1; tick(); ifA.in_valid = 0;
    chk("rt_we", weA, 1);
    chk("rt_addr", addrA, 0);
    chk("rt_wdata", wdataA, 32'h00221820);
    chk("rt_wc", wcA, 1);
    tick();
    chk("rt_we_pulse", weA, 0);

    endA = 1; tick(); endA = 0;
    chk("end_done", doneA, 1);
    chk("end_busy", busyA, 0);
    chk("end_ready", ifA.in_ready, 0);

    // Back-to-back LW, SW, J, BEQ
    startA = 1; tick(); startA = 0;
    chk("rs_wc0", wcA, 0);
    chk("rs_done", doneA, 0);
    setA(3'd4, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
    ifA.in_valid = 1; tick();
    chk("lw_we", weA, 1);
    chk("lw_addr", addrA, 0);
    chk("lw_wdata", wdataA, 32'h8D280004);
    setA(3'd5, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
    tick();
    chk("sw_we", weA, 1);
    chk("sw_addr", addrA, 1);
    chk("sw_wdata", wdataA, 32'hAD280004);
    setA(3'd1, 5'd9, 5'd8, 5'd7, 5'd6, 6'h3F, 16'hFFFF, 26'h0000010);
    tick();
    chk("j_addr", addrA, 2);
    chk("j_wdata", wdataA, 32'h08000010);
    setA(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    tick(); ifA.in_valid = 0;
    chk("beq_addr", addrA, 3);
    chk("beq_wdata", wdataA, 32'h1022FFFF);
    chk("beq_wc", wcA, 4);
    tick();
    chk("idle_we", weA, 0);

    // load_start ignored while loading
    startA = 1; tick(); startA = 0;
    chk("ign_wc", wcA, 4);
    chk("ign_busy", busyA, 1);

    // Illegal op_sel between two ADDIs, last one with load_end
    endA = 1; tick(); endA = 0;
    startA = 1; tick(); startA = 0;
    setA(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    ifA.in_valid = 1; tick();
    chk("ad1_addr", addrA, 0);
    chk("ad1_wdata", wdataA, 32'h20220005);
    chk("ad1_err", errA, 0);
    setA(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0005, 26'd0);
    tick();
    chk("ill_we", weA, 0);
    chk("ill_err", errA, 1);
    chk("ill_wc", wcA, 1);
    setA(3'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0);
    endA = 1; tick(); endA = 0; ifA.in_valid = 0;
    chk("ad2_we", weA, 1);
    chk("ad2_addr", addrA, 1);
    chk("ad2_wdata", wdataA, 32'h20640007);
    chk("ad2_wc", wcA, 2);
    chk("ad2_err", errA, 1);
    chk("ad2_done", doneA, 1);
    chk("ad2_ready", ifA.in_ready, 0);
    tick();
    chk("ad2_we_pulse", weA, 0);
    chk("done_err", errA, 1);

    // Restart clears counters and err, writes again at address 0
    startA = 1; tick(); startA = 0;
    chk("rs2_wc", wcA, 0);
    chk("rs2_err", errA, 0);
    chk("rs2_busy", busyA, 1);
    setA(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    ifA.in_valid = 1; tick(); ifA.in_valid = 0;
    chk("rs2_we", weA, 1);
    chk("rs2_addr", addrA, 0);

    // Checksum load, then asynchronous reset mid-stream
    endA = 1; tick(); endA = 0;
    startA = 1; tick(); startA = 0;
    setA(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
    ifA.in_valid = 1; tick();
    setA(3'd4, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
    tick();
    chk("cs_wdata", wdataA, 32'h8D280004);
`ifdef ENC_CHECKSUM_EN
    chk("cs_value", csumA, 32'h8D0A1824);
`endif
    setA(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
    rst_n = 1'b0;
    #2;
    chk("ar_we", weA, 0);
    chk("ar_busy", busyA, 0);
    chk("ar_ready", ifA.in_ready, 0);
    chk("ar_wc", wcA, 0);
    chk("ar_addr", addrA, 0);
    chk("ar_wdata", wdataA, 0);
`ifdef ENC_CHECKSUM_EN
    chk("ar_csum", csumA, 0);
`endif
    ifA.in_valid = 0;
    rst_n = 1'b1;
    tick();
    chk("ar_we_after", weA, 0);

    // ADDR_W=2: five words streamed, only four written
    startB = 1; tick(); startB = 0;
    chk("b_busy", busyB, 1);
    ifB.imm16 = 16'd0; ifB.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        chk("b_we", weB, 1);
        chk("b_addr", addrB, i);
        chk("b_wdata", wdataB, 32'h20220000 + i);
        chk("b_wc", wcB, i + 1);
        ifB.imm16 = 16'(i + 1);
      end else begin
        chk("b_stall_we", weB, 0);
        chk("b_stall_wc", wcB, 4);
      end
      if (i >= 3) begin
        chk("b_full", fullB, 1);
        chk("b_ready", ifB.in_ready, 0);
      end
    end
    ifB.in_valid = 0;
    endB = 1; tick(); endB = 0;
    chk("b_done", doneB, 1);
    chk("b_busy_end", busyB, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
